// File: rtl/operand_fetch_unit.sv
// Operand fetch stage in front of a dual-read-port data RAM with registered,
// read-before-write outputs. Instructions pass through a read-issued stage
// (S1) and an output register (OUT). Write-back traffic is snooped so that
// every delivered operand reflects all writes up to the cycle it is consumed.

`ifndef DATA_ROW_WIDTH
`define DATA_ROW_WIDTH 32
`endif
`ifndef DATA_ADDRESS_WIDTH
`define DATA_ADDRESS_WIDTH 8
`endif

module operand_fetch_unit #(
    parameter int DATA_WIDTH = `DATA_ROW_WIDTH,
    parameter int ADDR_WIDTH = `DATA_ADDRESS_WIDTH,
    parameter int OP_WIDTH   = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iInstrValid,
    output logic                  oInstrReady,
    input  logic [OP_WIDTH-1:0]   iOpcode,
    input  logic [ADDR_WIDTH-1:0] iDestination,
    input  logic [ADDR_WIDTH-1:0] iSource0,
    input  logic [ADDR_WIDTH-1:0] iSource1,
    output logic [ADDR_WIDTH-1:0] oReadAddress0,
    output logic [ADDR_WIDTH-1:0] oReadAddress1,
    input  logic [DATA_WIDTH-1:0] iRamData0,
    input  logic [DATA_WIDTH-1:0] iRamData1,
    input  logic                  iWriteEnable,
    input  logic [ADDR_WIDTH-1:0] iWriteAddress,
    input  logic [DATA_WIDTH-1:0] iWriteData,
    output logic                  oOperandValid,
    input  logic                  iOperandReady,
    output logic [OP_WIDTH-1:0]   oOpcode,
    output logic [ADDR_WIDTH-1:0] oDestination,
    output logic [DATA_WIDTH-1:0] oOperand0,
    output logic [DATA_WIDTH-1:0] oOperand1
);

    // Shared pipeline control state
    logic                  s1_valid_q, s1_valid_d;
    logic [OP_WIDTH-1:0]   s1_opcode_q, s1_opcode_d;
    logic [ADDR_WIDTH-1:0] s1_dest_q, s1_dest_d;
    logic                  out_valid_q, out_valid_d;
    logic [OP_WIDTH-1:0]   out_opcode_q, out_opcode_d;
    logic [ADDR_WIDTH-1:0] out_dest_q, out_dest_d;

    logic accept;
    logic adv;

    // Per-port views of the two read ports so both share one generate body
    logic [ADDR_WIDTH-1:0] src_in   [2];
    logic [DATA_WIDTH-1:0] ram_in   [2];
    logic [ADDR_WIDTH-1:0] rd_addr  [2];
    logic [DATA_WIDTH-1:0] operand  [2];

    assign src_in[0] = iSource0;
    assign src_in[1] = iSource1;
    assign ram_in[0] = iRamData0;
    assign ram_in[1] = iRamData1;

    // S1 moves into OUT whenever OUT is empty or being drained this cycle;
    // ready therefore depends combinationally on the downstream ready.
    assign adv         = s1_valid_q & (~out_valid_q | iOperandReady);
    assign oInstrReady = ~s1_valid_q | adv;
    assign accept      = iInstrValid & oInstrReady;

    assign oReadAddress0 = rd_addr[0];
    assign oReadAddress1 = rd_addr[1];
    assign oOperand0     = operand[0];
    assign oOperand1     = operand[1];
    assign oOperandValid = out_valid_q;
    assign oOpcode       = out_opcode_q;
    assign oDestination  = out_dest_q;

    // Next-state of the S1 and OUT control/pass-through fields
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_opcode_d  = s1_opcode_q;
        s1_dest_d    = s1_dest_q;
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_dest_d   = out_dest_q;
        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_opcode_d = iOpcode;
            s1_dest_d   = iDestination;
        end else if (adv) begin
            s1_valid_d = 1'b0;
        end
        if (adv) begin
            out_valid_d  = 1'b1;
            out_opcode_d = s1_opcode_q;
            out_dest_d   = s1_dest_q;
        end else if (iOperandReady) begin
            out_valid_d = 1'b0;
        end
    end

    // Control registers; reset discards anything in flight
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_valid_q   <= 1'b0;
            s1_opcode_q  <= '0;
            s1_dest_q    <= '0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_dest_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_opcode_q  <= s1_opcode_d;
            s1_dest_q    <= s1_dest_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_dest_q   <= out_dest_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_WIDTH-1:0] s1_src_q, s1_src_d;
            logic [ADDR_WIDTH-1:0] out_src_q, out_src_d;
            logic                  fwd_hit_q, fwd_hit_d;
            logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
            logic [DATA_WIDTH-1:0] out_operand_q, out_operand_d;
            logic [DATA_WIDTH-1:0] merged;

            // A held S1 keeps re-reading its own source so RAM data stays current
            assign rd_addr[gi] = (accept | ~s1_valid_q) ? src_in[gi] : s1_src_q;
            assign operand[gi] = out_operand_q;

            // Operand merge: live write beats last-cycle write beats RAM data
            always_comb begin
                merged = ram_in[gi];
                if (iWriteEnable && (iWriteAddress == s1_src_q)) begin
                    merged = iWriteData;
                end else if (fwd_hit_q) begin
                    merged = fwd_data_q;
                end
                // The RAM returns pre-write data when read and write collide,
                // so remember such a write for the cycle the data comes back.
                fwd_hit_d     = iWriteEnable && (iWriteAddress == rd_addr[gi]);
                fwd_data_d    = iWriteData;
                s1_src_d      = accept ? src_in[gi] : s1_src_q;
                out_src_d     = out_src_q;
                out_operand_d = out_operand_q;
                if (adv) begin
                    out_src_d     = s1_src_q;
                    out_operand_d = merged;
                end else if (out_valid_q && iWriteEnable && (iWriteAddress == out_src_q)) begin
                    out_operand_d = iWriteData;
                end
            end

            // Per-port source, forward and operand registers
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    s1_src_q      <= '0;
                    out_src_q     <= '0;
                    fwd_hit_q     <= 1'b0;
                    fwd_data_q    <= '0;
                    out_operand_q <= '0;
                end else begin
                    s1_src_q      <= s1_src_d;
                    out_src_q     <= out_src_d;
                    fwd_hit_q     <= fwd_hit_d;
                    fwd_data_q    <= fwd_data_d;
                    out_operand_q <= out_operand_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a behavioural dual-port RAM
// (registered read, read-before-write). RAM word i starts as 0xA0000000|i.
module tb_operand_fetch_unit;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          Reset;
    logic          iInstrValid;
    logic          oInstrReady;
    logic [OW-1:0] iOpcode;
    logic [AW-1:0] iDestination, iSource0, iSource1;
    logic [AW-1:0] oReadAddress0, oReadAddress1;
    logic [DW-1:0] iRamData0, iRamData1;
    logic          iWriteEnable;
    logic [AW-1:0] iWriteAddress;
    logic [DW-1:0] iWriteData;
    logic          oOperandValid;
    logic          iOperandReady;
    logic [OW-1:0] oOpcode;
    logic [AW-1:0] oDestination;
    logic [DW-1:0] oOperand0, oOperand1;

    logic          ram_init;
    logic [DW-1:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
        .Clock(clk), .Reset(Reset),
        .iInstrValid(iInstrValid), .oInstrReady(oInstrReady),
        .iOpcode(iOpcode), .iDestination(iDestination),
        .iSource0(iSource0), .iSource1(iSource1),
        .oReadAddress0(oReadAddress0), .oReadAddress1(oReadAddress1),
        .iRamData0(iRamData0), .iRamData1(iRamData1),
        .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress), .iWriteData(iWriteData),
        .oOperandValid(oOperandValid), .iOperandReady(iOperandReady),
        .oOpcode(oOpcode), .oDestination(oDestination),
        .oOperand0(oOperand0), .oOperand1(oOperand1)
    );

    // Behavioural data RAM: registered reads see the pre-write contents
    always @(posedge clk) begin
        iRamData0 <= mem[oReadAddress0];
        iRamData1 <= mem[oReadAddress1];
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else if (iWriteEnable) begin
            mem[iWriteAddress] <= iWriteData;
        end
    end

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  dst;
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] dst,
                         input logic [7:0] s0, input logic [7:0] s1,
                         input logic w, input logic [7:0] wa, input logic [31:0] wd,
                         input logic rdy);
        iInstrValid   = v;
        iOpcode       = op;
        iDestination  = dst;
        iSource0      = s0;
        iSource1      = s1;
        iWriteEnable  = w;
        iWriteAddress = wa;
        iWriteData    = wd;
        iOperandReady = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 32'h0, rdy);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [7:0] op, input logic [7:0] dst,
                             input logic [31:0] e0, input logic [31:0] e1);
        check({name, ".valid"}, 64'(oOperandValid), 64'd1);
        check({name, ".opcode"}, 64'(oOpcode), 64'(op));
        check({name, ".dest"}, 64'(oDestination), 64'(dst));
        check({name, ".op0"}, 64'(oOperand0), 64'(e0));
        check({name, ".op1"}, 64'(oOperand1), 64'(e1));
        $display("txn %s: opcode=%02h dest=%02h op0=%08h op1=%08h", name, oOpcode, oDestination, oOperand0, oOperand1);
    endtask

    initial begin
        vecs[0] = '{8'h21, 8'h01, 8'h00, 8'h01, 32'hA000_0000, 32'hA000_0001};
        vecs[1] = '{8'h22, 8'h02, 8'h10, 8'h20, 32'hA000_0010, 32'hA000_0020};
        vecs[2] = '{8'h23, 8'h03, 8'hFF, 8'hFE, 32'hA000_00FF, 32'hA000_00FE};
        vecs[3] = '{8'h24, 8'h04, 8'h07, 8'h07, 32'hA000_0007, 32'hA000_0007};
        vecs[4] = '{8'h25, 8'h05, 8'h40, 8'h41, 32'hA000_0040, 32'hA000_0041};
        vecs[5] = '{8'h26, 8'h06, 8'h05, 8'h03, 32'hA000_0005, 32'hA000_0003};
        vecs[6] = '{8'h27, 8'h07, 8'h80, 8'h81, 32'hA000_0080, 32'hA000_0081};
        vecs[7] = '{8'h28, 8'h08, 8'h0F, 8'hF0, 32'hA000_000F, 32'hA000_00F0};

        // Reset state
        Reset = 1'b1;
        ram_init = 1'b1;
        idle(1'b1);
        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b0;
        ram_init = 1'b0;
        @(negedge clk);
        check("rst.valid", 64'(oOperandValid), 64'd0);
        check("rst.op0", 64'(oOperand0), 64'd0);
        check("rst.op1", 64'(oOperand1), 64'd0);
        check("rst.opcode", 64'(oOpcode), 64'd0);
        check("rst.dest", 64'(oDestination), 64'd0);
        check("rst.ready", 64'(oInstrReady), 64'd1);

        // Single fetch: src 3/5, dest 7, opcode 0x12
        to_drive();
        drive(1'b1, 8'h12, 8'h07, 8'h03, 8'h05, 1'b0, 8'h00, 32'h0, 1'b1);
        @(negedge clk);
        check("single.raddr0", 64'(oReadAddress0), 64'd3);
        check("single.raddr1", 64'(oReadAddress1), 64'd5);
        check("single.ready", 64'(oInstrReady), 64'd1);
        to_drive();
        idle(1'b1);
        @(negedge clk);
        check("single.early_valid", 64'(oOperandValid), 64'd0);
        to_drive();
        @(negedge clk);
        check_out("single", 8'h12, 8'h07, 32'hA000_0003, 32'hA000_0005);
        to_drive();
        @(negedge clk);
        check("single.drain", 64'(oOperandValid), 64'd0);

        // Back-to-back with ready held high
        for (int k = 0; k < 10; k++) begin
            to_drive();
            if (k < 8) drive(1'b1, vecs[k].op, vecs[k].dst, vecs[k].s0, vecs[k].s1, 1'b0, 8'h00, 32'h0, 1'b1);
            else idle(1'b1);
            @(negedge clk);
            if (k < 8) check($sformatf("b2b%0d.ready", k), 64'(oInstrReady), 64'd1);
            if (k >= 2) check_out($sformatf("b2b%0d", k - 2), vecs[k-2].op, vecs[k-2].dst, vecs[k-2].e0, vecs[k-2].e1);
        end
        to_drive();
        @(negedge clk);
        check("b2b.drain", 64'(oOperandValid), 64'd0);

        // Hazard: write to src0 in the accept cycle (RAM returns old data)
        to_drive();
        drive(1'b1, 8'h31, 8'h01, 8'h03, 8'h05, 1'b1, 8'h03, 32'hC0C0_0001, 1'b1);
        to_drive();
        idle(1'b1);
        to_drive();
        @(negedge clk);
        check_out("haz_accept", 8'h31, 8'h01, 32'hC0C0_0001, 32'hA000_0005);

        // Hazard: write to src0 in the cycle after accept
        to_drive();
        drive(1'b1, 8'h32, 8'h02, 8'h03, 8'h04, 1'b0, 8'h00, 32'h0, 1'b1);
        to_drive();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h03, 32'hD0D0_0002, 1'b1);
        to_drive();
        idle(1'b1);
        @(negedge clk);
        check_out("haz_next", 8'h32, 8'h02, 32'hD0D0_0002, 32'hA000_0004);

        // Stall with S1 and OUT full; snoop writes to OUT and S1 sources
        to_drive();
        drive(1'b1, 8'h41, 8'h0A, 8'h10, 8'h11, 1'b0, 8'h00, 32'h0, 1'b0);
        to_drive();
        drive(1'b1, 8'h42, 8'h0B, 8'h12, 8'h13, 1'b0, 8'h00, 32'h0, 1'b0);
        @(negedge clk);
        check("stall.ready_fill", 64'(oInstrReady), 64'd1);
        for (int c = 2; c <= 6; c++) begin
            to_drive();
            case (c)
                3: drive(1'b1, 8'h43, 8'h0C, 8'h14, 8'h15, 1'b1, 8'h10, 32'hE000_0000, 1'b0);
                4: drive(1'b1, 8'h43, 8'h0C, 8'h14, 8'h15, 1'b1, 8'h13, 32'hE000_0001, 1'b0);
                5: drive(1'b1, 8'h43, 8'h0C, 8'h14, 8'h15, 1'b1, 8'h11, 32'hE000_0002, 1'b0);
                default: drive(1'b1, 8'h43, 8'h0C, 8'h14, 8'h15, 1'b0, 8'h00, 32'h0, 1'b0);
            endcase
            @(negedge clk);
            check($sformatf("stall%0d.ready", c), 64'(oInstrReady), 64'd0);
            check($sformatf("stall%0d.valid", c), 64'(oOperandValid), 64'd1);
            check($sformatf("stall%0d.opcode", c), 64'(oOpcode), 64'h41);
        end
        check_out("stall_out", 8'h41, 8'h0A, 32'hE000_0000, 32'hE000_0002);
        to_drive();
        drive(1'b1, 8'h43, 8'h0C, 8'h14, 8'h15, 1'b0, 8'h00, 32'h0, 1'b1);
        @(negedge clk);
        check("stall.release_ready", 64'(oInstrReady), 64'd1);
        check("stall.release_opcode", 64'(oOpcode), 64'h41);
        to_drive();
        idle(1'b1);
        @(negedge clk);
        check_out("stall_s1", 8'h42, 8'h0B, 32'hA000_0012, 32'hE000_0001);
        to_drive();
        @(negedge clk);
        check_out("stall_i3", 8'h43, 8'h0C, 32'hA000_0014, 32'hA000_0015);
        to_drive();
        @(negedge clk);
        check("stall.drain", 64'(oOperandValid), 64'd0);

        // src0 == src1 == 9 with a write to 9 on the accept cycle
        to_drive();
        drive(1'b1, 8'h51, 8'h09, 8'h09, 8'h09, 1'b1, 8'h09, 32'hF00D_0009, 1'b1);
        to_drive();
        idle(1'b1);
        to_drive();
        @(negedge clk);
        check_out("same_src", 8'h51, 8'h09, 32'hF00D_0009, 32'hF00D_0009);

        // Reset with S1 and OUT full, then a fresh instruction
        to_drive();
        drive(1'b1, 8'h61, 8'h01, 8'h20, 8'h21, 1'b0, 8'h00, 32'h0, 1'b0);
        to_drive();
        drive(1'b1, 8'h62, 8'h02, 8'h22, 8'h23, 1'b0, 8'h00, 32'h0, 1'b0);
        to_drive();
        Reset = 1'b1;
        idle(1'b0);
        @(negedge clk);
        check("mrst.full_before", 64'(oOperandValid), 64'd1);
        to_drive();
        Reset = 1'b0;
        drive(1'b1, 8'h55, 8'h33, 8'h24, 8'h25, 1'b0, 8'h00, 32'h0, 1'b1);
        @(negedge clk);
        check("mrst.valid", 64'(oOperandValid), 64'd0);
        check("mrst.op0", 64'(oOperand0), 64'd0);
        check("mrst.op1", 64'(oOperand1), 64'd0);
        check("mrst.opcode", 64'(oOpcode), 64'd0);
        check("mrst.dest", 64'(oDestination), 64'd0);
        check("mrst.ready", 64'(oInstrReady), 64'd1);
        to_drive();
        idle(1'b1);
        @(negedge clk);
        check("mrst.no_stale", 64'(oOperandValid), 64'd0);
        to_drive();
        @(negedge clk);
        check_out("mrst_new", 8'h55, 8'h33, 32'hA000_0024, 32'hA000_0025);
        to_drive();
        @(negedge clk);
        check("mrst.drain", 64'(oOperandValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Operand fetch stage that sits directly upstream of the dual-read-port data RAM. It accepts decoded instructions over a valid/ready handshake and drives the RAM's two read addresses. It captures the registered read data one cycle later and hands opcode, destination and both operands to the execute stage over a second valid/ready handshake. It snoops the write-back port so that every delivered operand is coherent with all writes up to the cycle it is consumed.

## Interface
Parameters:
- DATA_WIDTH, `DATA_ROW_WIDTH, operand/row width
- ADDR_WIDTH, `DATA_ADDRESS_WIDTH, RAM address width
- OP_WIDTH, 8, opcode width

Ports:
- Clock  in  1  single clock, all state on posedge
- Reset  in  1  synchronous, active-high
- iInstrValid  in  1  upstream instruction valid
- oInstrReady  out  1  fetch unit can accept
- iOpcode  in  OP_WIDTH  instruction opcode
- iDestination  in  ADDR_WIDTH  destination address, passed through
- iSource0 / iSource1  in  ADDR_WIDTH  source addresses
- oReadAddress0 / oReadAddress1  out  ADDR_WIDTH  to RAM read ports
- iRamData0 / iRamData1  in  DATA_WIDTH  RAM read data, registered, 1-cycle latency, read-before-write
- iWriteEnable  in  1  write-back strobe, also wired to RAM
- iWriteAddress  in  ADDR_WIDTH  write-back address
- iWriteData  in  DATA_WIDTH  write-back data
- oOperandValid  out  1  operands valid to execute
- iOperandReady  in  1  execute accepts
- oOpcode, oDestination, oOperand0, oOperand1  out  held with oOperandValid

## Operation
- Two stages: S1 is the read-issued stage; OUT is the output register.
- Accept = iInstrValid & oInstrReady. On accept, S1 loads opcode, destination and sources.
- S1 advance: adv = S1valid & (~oOperandValid | iOperandReady).
- oInstrReady = ~S1valid | adv. This path is combinational from iOperandReady.
- Read addresses are combinational:
  - On accept or when S1 is empty: oReadAddressN = iSourceN.
  - Otherwise: the held S1 sources.
  - A stalled S1 re-reads its sources every cycle.
- Forward register per port: each cycle, FwdHitN <= iWriteEnable & (iWriteAddress == oReadAddressN) and FwdDataN <= iWriteData. This covers the RAM returning stale data for a same-cycle write.
- S1 operand merge, per port, priority order:
  - iWriteEnable & iWriteAddress == S1srcN → iWriteData
  - else FwdHitN → FwdDataN
  - else iRamDataN
- On adv, OUT loads the merged operands, opcode and destination; oOperandValid <= 1.
- If OUT is consumed with no adv: oOperandValid <= 0.
- OUT snoop: while oOperandValid and not reloading, a write to OUT's source address replaces oOperandN. OUT keeps both source addresses internally for this.
- src0 == src1 is legal; both ports merge identically.

## Timing
- Reset: oOperandValid=0, oOperand0/1=0, oOpcode=0, oDestination=0, S1valid=0, FwdHit=0, oInstrReady=1 (combinational after reset).
- A Reset asserted mid-operation discards S1 and OUT contents; no partial delivery.
- Latency: accept at edge T → oOperandValid high from edge T+2. Throughput is 1 instruction/cycle with iOperandReady held high.
- Handshakes:
  - oOperandValid and all outputs stay stable until iOperandReady is sampled high, except snoop updates of oOperandN.
  - Upstream may drop iInstrValid at any time.
- Simultaneous events:
  - Consume and reload in the same cycle → new item, no bubble.
  - Write matching the S1 source in the same cycle as adv → the new data enters OUT.

## Test plan
- Single fetch: RAM[3]=A, RAM[5]=B; accept opcode 0x12, src 3/5, dest 7 → two cycles later oOperand0=A, oOperand1=B, oOpcode=0x12, oDestination=7; oReadAddress0/1=3/5 at accept.
- Back-to-back: 8 instructions with ready held high → 8 consecutive oOperandValid cycles, in order, oInstrReady never low.
- Same-cycle hazard: write RAM[3]=C in the accept cycle of src0=3 (RAM returns old A) → oOperand0=C. Repeat with the write in cycle T+1 → oOperand0=C.
- Stall + snoop: hold iOperandReady=0 for 5 cycles with S1 and OUT full. Write src addresses of both → OUT shows new data, S1 delivers new data, oInstrReady=0 throughout, no loss or duplication.
- src0==src1==9 with a write to 9 on the accept cycle → both operands equal the write data.
- Reset with S1 and OUT full → next cycle oOperandValid=0, all outputs 0. The next accepted instruction delivers correctly at T+2.
